spi_tx_queue: RTL and testbench
===============================

SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, byte width handed to the SPI master.
REQ-002 The block SHALL have parameter DEPTH, default 8, FIFO entries, power of two, 2..64.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, idle clocks between a finish edge and the next start pulse, range 0..15.
REQ-004 The block SHALL have port clk input 1: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst input 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port wr_en input 1: push wr_data when asserted.
REQ-007 The block SHALL have port wr_data input DATA_W: byte to queue.
REQ-008 The block SHALL have port en input 1: permits launching new transfers.
REQ-009 The block SHALL have port spi_finish input 1: master's finish signal, level.
REQ-010 The block SHALL have port spi_start output 1: one-cycle start pulse to the master.
REQ-011 The block SHALL have port spi_data output DATA_W: data_in to the master, stable from the start pulse until the finish edge.
REQ-012 The block SHALL have ports full, empty output 1: FIFO status.
REQ-013 The block SHALL have port level output $clog2(DEPTH)+1: entries held.
REQ-014 The block SHALL have port busy output 1: high whenever the state is not IDLE.

Function
REQ-015 The FIFO SHALL accept a push when wr_en=1 and full=0; a push while full is dropped with contents unchanged.
REQ-016 The FSM SHALL have states IDLE, LOAD, START, WAIT_FIN, GAP.
REQ-017 IDLE SHALL go to LOAD when en=1 and empty=0, popping one entry in that cycle.
REQ-018 LOAD SHALL register the popped entry into spi_data, then go to START.
REQ-019 START SHALL drive spi_start=1 for exactly that one cycle, then go to WAIT_FIN.
REQ-020 Completion SHALL be a rising edge of spi_finish (current=1, registered previous=0) seen in WAIT_FIN; a finish already high on entry does not count.
REQ-021 WAIT_FIN SHALL go to GAP on completion, or directly to IDLE when GAP_CYCLES=0.
REQ-022 GAP SHALL count GAP_CYCLES clocks, then go to IDLE.
REQ-023 Latency SHALL be: a push into an empty FIFO in IDLE with en=1 gives spi_start high 3 clocks after the push edge.
REQ-024 A push and a pop in the same cycle SHALL both take effect, leaving level unchanged; this is legal when full=1 (pop frees the slot) and when empty=0.
REQ-025 Pointers SHALL wrap modulo DEPTH; level = pushes minus pops, never exceeding DEPTH.
REQ-026 Deasserting en SHALL affect only the IDLE->LOAD transition; a transfer in progress completes.

Reset
REQ-027 While rst=0, the block SHALL set: state IDLE, pointers 0, level 0, empty=1, full=0, spi_start=0, spi_data=0, busy=0, finish-edge register 0, gap counter 0.
REQ-028 Reset mid-transfer SHALL abort immediately and discard queued entries; no start pulse is issued until a new push after release.

Configuration
REQ-029 With SPI_TXQ_OVERFLOW_EN defined, the block SHALL add input ovf_clr (1) and output overflow (1): overflow is sticky, set on a dropped push, cleared by ovf_clr or reset; set wins over a simultaneous clear.
REQ-030 Without SPI_TXQ_OVERFLOW_EN, neither port SHALL exist and dropped pushes SHALL be silent.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state typedef (txq_state_t) and the default DATA_W constant.
REQ-032 Storage and pointers SHALL be sub-module spi_txq_fifo (sync FIFO: push/pop/full/empty/level); spi_tx_queue holds the FSM, the gap counter and the edge detect.

Verification
REQ-033 Single byte: push 8'hDB, en=1, master modelled with a finish pulse -> one spi_start 3 clocks later, spi_data=8'hDB until the finish edge, busy back to 0 after GAP.
REQ-034 Back-to-back: push 8'h01, 8'h02, 8'h03 -> three start pulses in order, each exactly GAP_CYCLES+2 clocks after the previous finish edge.
REQ-035 Full: DEPTH=8, en=0, nine pushes -> full=1, level=8, ninth byte lost; with SPI_TXQ_OVERFLOW_EN, overflow=1 until ovf_clr.
REQ-036 Simultaneous: full FIFO, push while IDLE pops -> level stays 8, new byte emitted last.
REQ-037 Stale finish: spi_finish held high at start of WAIT_FIN -> no completion until it drops and rises again.
REQ-038 Reset mid-transfer: pull rst low in WAIT_FIN with 4 queued -> all outputs at reset values asynchronously, level=0, no start pulse after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared FSM state type and default data width for the SPI transmit queue.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_FIN,
    GAP
  } txq_state_t;

endpackage

// File: rtl/spi_txq_fifo.sv
// Synchronous FIFO for the SPI transmit queue: registered flags, level and read data.
// A pop loads the head entry into rd_data on the same edge the read pointer advances.
module spi_txq_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              push_ok, pop_ok;

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
  always_comb begin
    pop_ok    = pop && !empty_q;
    push_ok   = push && (!full_q || pop_ok);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/spi_tx_queue.sv
// Byte queue feeding an SPI master: FIFO, start/finish handshake FSM and inter-transfer gap.
// Optional sticky overflow flag with ovf_clr when SPI_TXQ_OVERFLOW_EN is defined.
module spi_tx_queue
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = SPI_DATA_W,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   en,
  input  logic                   spi_finish,
`ifdef SPI_TXQ_OVERFLOW_EN
  input  logic                   ovf_clr,
  output logic                   overflow,
`endif
  output logic                   spi_start,
  output logic [DATA_W-1:0]      spi_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  txq_state_t        state_q, state_d;
  logic [DATA_W-1:0] spi_data_q, spi_data_d;
  logic              spi_start_q, spi_start_d;
  logic              busy_q, busy_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              fin_prev_q;
  logic              avail_q;
  logic              fin_rise;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_rd_data;

  spi_txq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Launch needs avail_q too: a freshly written entry settles one cycle before it is popped.
  always_comb begin
    state_d    = state_q;
    spi_data_d = spi_data_q;
    gap_cnt_d  = gap_cnt_q;
    fifo_pop   = 1'b0;
    fin_rise   = spi_finish && !fin_prev_q;
    unique case (state_q)
      IDLE: begin
        if (en && avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        spi_data_d = fifo_rd_data;
        state_d    = START;
      end
      START: state_d = WAIT_FIN;
      WAIT_FIN: begin
        if (fin_rise) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    spi_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      spi_data_q  <= '0;
      spi_start_q <= 1'b0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= '0;
      fin_prev_q  <= 1'b0;
      avail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      spi_data_q  <= spi_data_d;
      spi_start_q <= spi_start_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
      fin_prev_q  <= spi_finish;
      avail_q     <= !fifo_empty;
    end
  end

`ifdef SPI_TXQ_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A push against a full FIFO with no pop that cycle is dropped; set beats clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_en && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;
  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Self-checking bench for spi_tx_queue: scoreboarded transfers, fill table, corner sequences.
module tb_spi_tx_queue;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned GAP    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       en;
  logic       fin_auto;
  logic       fin_man;
  logic       spi_finish;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       busy;
`ifdef SPI_TXQ_OVERFLOW_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit auto_fin;
  logic [7:0] exp_q[$];
  int start_edges[$];
  int fin_edges[$];
  logic [7:0] mon_exp;
  logic [7:0] held;
  int push_edge;
  int idle_cyc;
  int fin_edge;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       keep;
  } vec_t;
  vec_t tbl[10];

  assign spi_finish = fin_auto | fin_man;

  spi_tx_queue #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .en         (en),
    .spi_finish (spi_finish),
`ifdef SPI_TXQ_OVERFLOW_EN
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
`endif
    .spi_start  (spi_start),
    .spi_data   (spi_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int t = 0;
    while (start_edges.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (start_edges.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_starts: saw %0d starts, required %0d", start_edges.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, output int at);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      tick();
      t++;
    end
    at = cyc;
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  // Scoreboard: every start pulse must carry the oldest accepted byte.
  always @(posedge clk) begin
    #1;
    if (spi_start === 1'b1) begin
      start_edges.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: start at cycle %0d, data %0h, nothing queued", cyc, spi_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (spi_data !== mon_exp) begin
          errors++;
          $display("FAIL spi_data: got %0h expected %0h (cycle %0d)", spi_data, mon_exp, cyc);
        end
      end
    end
  end

  // Master model: one-cycle finish pulse three clocks after start.
  always begin
    @(posedge clk);
    #1;
    if (spi_start === 1'b1 && auto_fin) begin
      held = spi_data;
      repeat (3) @(posedge clk);
      #1;
      check("data_stable", spi_data, held);
      fin_auto = 1'b1;
      fin_edges.push_back(cyc + 1);
      @(posedge clk);
      #1;
      fin_auto = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    en       = 1'b0;
    fin_auto = 1'b0;
    fin_man  = 1'b0;
    auto_fin = 1'b1;
`ifdef SPI_TXQ_OVERFLOW_EN
    ovf_clr  = 1'b0;
`endif
    for (int i = 0; i < 10; i++) begin
      tbl[i].wr    = (i < 9);
      tbl[i].data  = 8'h10 + 8'(i);
      tbl[i].lvl   = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].full  = (i >= 7);
      tbl[i].empty = 1'b0;
      tbl[i].ovf   = (i >= 8);
      tbl[i].keep  = (i < 8);
    end

    #3 rst = 1'b0;
    tick();
    tick();
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_data", spi_data, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
`ifdef SPI_TXQ_OVERFLOW_EN
    check("rst_overflow", overflow, 0);
`endif
    rst = 1'b1;
    tick();

    // Single byte
    en = 1'b1;
    start_edges.delete();
    fin_edges.delete();
    push_edge = cyc + 1;
    push(8'hDB);
    wait_starts(1, 20);
    check("single_busy", busy, 1);
    if (start_edges.size() >= 1) check("single_latency", start_edges[0], push_edge + 3);
    wait_idle(40, idle_cyc);
    if (fin_edges.size() >= 1) check("single_idle_after_gap", idle_cyc, fin_edges[0] + GAP);

    // Back-to-back
    start_edges.delete();
    fin_edges.delete();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_starts(3, 60);
    wait_idle(60, idle_cyc);
    check("b2b_fin_count", fin_edges.size(), 3);
    if (start_edges.size() == 3 && fin_edges.size() >= 2) begin
      for (int i = 1; i < 3; i++) begin
        check($sformatf("b2b_gap[%0d]", i), start_edges[i], fin_edges[i-1] + GAP + 2);
      end
    end

    // Fill with en=0: ninth byte dropped
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].data;
      if (tbl[i].keep) exp_q.push_back(tbl[i].data);
      tick();
      check($sformatf("fill_level[%0d]", i), level, tbl[i].lvl);
      check($sformatf("fill_full[%0d]", i), full, tbl[i].full);
      check($sformatf("fill_empty[%0d]", i), empty, tbl[i].empty);
`ifdef SPI_TXQ_OVERFLOW_EN
      check($sformatf("fill_ovf[%0d]", i), overflow, tbl[i].ovf);
`endif
    end
    wr_en = 1'b0;
`ifdef SPI_TXQ_OVERFLOW_EN
    tick();
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
`endif

    // Simultaneous push and pop on a full FIFO
    start_edges.delete();
    fin_edges.delete();
    en      = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("simul_level", level, 8);
    check("simul_full", full, 1);
`ifdef SPI_TXQ_OVERFLOW_EN
    check("simul_no_ovf", overflow, 0);
`endif
    wait_starts(9, 200);
    wait_idle(60, idle_cyc);
    check("drain_count", start_edges.size(), 9);
    check("drain_level", level, 0);
    check("drain_empty", empty, 1);

    // Stale finish held high on entry to WAIT_FIN
    auto_fin = 1'b0;
    fin_man  = 1'b1;
    start_edges.delete();
    tick();
    push(8'h5C);
    wait_starts(1, 20);
    repeat (6) tick();
    check("stale_busy_high", busy, 1);
    fin_man = 1'b0;
    tick();
    tick();
    check("stale_busy_low", busy, 1);
    fin_edge = cyc + 1;
    fin_man  = 1'b1;
    wait_idle(20, idle_cyc);
    check("stale_idle", idle_cyc, fin_edge + GAP);
    fin_man = 1'b0;
    check("scoreboard_empty", exp_q.size(), 0);

    // Reset mid-transfer with four entries queued
    en = 1'b0;
    start_edges.delete();
    tick();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    en = 1'b1;
    wait_starts(1, 20);
    tick();
    check("pre_reset_level", level, 4);
    check("pre_reset_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_spi_start", spi_start, 0);
    check("arst_spi_data", spi_data, 0);
    check("arst_busy", busy, 0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    start_edges.delete();
    repeat (20) tick();
    check("no_start_after_reset", start_edges.size(), 0);
    check("post_reset_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
